// File: rtl/fft_cal_pkg.sv
// Shared types and constants for the FFT bin-pair alignment block.
package fft_cal_pkg;
  localparam int NFFT_DEFAULT = 2048;
  localparam int SAMPLE_W     = 24;
  localparam int BIN_W        = 48;

  typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

  function automatic logic signed [SAMPLE_W-1:0] bin_re(input logic [BIN_W-1:0] b);
    return b[SAMPLE_W-1:0];
  endfunction

  function automatic logic signed [SAMPLE_W-1:0] bin_im(input logic [BIN_W-1:0] b);
    return b[BIN_W-1:SAMPLE_W];
  endfunction
endpackage

// File: rtl/fft_pair_align_if.sv
// AXI-stream style channel carrying one complex FFT bin per beat.
interface fft_pair_align_if;
  import fft_cal_pkg::*;
  logic [BIN_W-1:0] tdata;
  logic             tvalid;
  logic             tlast;
  logic             tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty and fall-through read data.
module sync_fifo #(
  parameter int WIDTH = 49,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr, r_rd;
  logic [AW:0]      r_cnt, w_cnt_nxt;
  logic             r_full, r_empty;
  logic             w_push, w_pop;

  // A full FIFO still accepts a write when a read frees the slot in the same cycle.
  assign w_pop  = pop && !r_empty;
  assign w_push = push && (!r_full || w_pop);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_push && !w_pop)      w_cnt_nxt = r_cnt + (AW+1)'(1);
    else if (w_pop && !w_push) w_cnt_nxt = r_cnt - (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_cnt   <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt   <= w_cnt_nxt;
      r_full  <= (w_cnt_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_cnt_nxt == '0);
    end
  end

  assign dout  = r_mem[r_rd];
  assign full  = r_full;
  assign empty = r_empty;
endmodule

// File: rtl/fft_pair_align.sv
// Pairs reference (x) and measured (y) FFT bins into frame-indexed outputs.
// Optional build macro FFT_ALIGN_ERR_CNT_EN adds a saturating err_cnt output.
module fft_pair_align
  import fft_cal_pkg::*;
#(
  parameter  int NFFT       = NFFT_DEFAULT,
  parameter  int FIFO_DEPTH = 16,
  localparam int IDX_W      = $clog2(NFFT)
) (
  input  logic                       clk,
  input  logic                       rst,
  fft_pair_align_if.slave            x_s,
  fft_pair_align_if.slave            y_s,
  output logic signed [SAMPLE_W-1:0] x_re,
  output logic signed [SAMPLE_W-1:0] x_im,
  output logic signed [SAMPLE_W-1:0] y_re,
  output logic signed [SAMPLE_W-1:0] y_im,
  output logic                       pair_valid,
  output logic [IDX_W-1:0]           bin_idx,
  output logic                       fft_out_valid,
`ifdef FFT_ALIGN_ERR_CNT_EN
  output logic [15:0]                err_cnt,
`endif
  output logic                       align_err
);
  logic [BIN_W:0] w_x_dout, w_y_dout;
  logic           w_x_full, w_y_full, w_x_empty, w_y_empty;
  logic           w_x_push, w_y_push, w_pop;
  logic           w_last_bin, w_any_last, w_err;

  state_t                     r_state;
  logic [IDX_W-1:0]           r_cnt;
  logic [IDX_W-1:0]           r_bin_idx_p1;
  logic                       r_vld_p1, r_fov_p1, r_err_p1;
  logic signed [SAMPLE_W-1:0] r_x_re_p1, r_x_im_p1, r_y_re_p1, r_y_im_p1;

  assign x_s.tready = !w_x_full;
  assign y_s.tready = !w_y_full;
  assign w_x_push   = x_s.tvalid && !w_x_full;
  assign w_y_push   = y_s.tvalid && !w_y_full;

  sync_fifo #(.WIDTH(BIN_W+1), .DEPTH(FIFO_DEPTH)) u_x_fifo (
    .clk(clk), .rst(rst), .push(w_x_push), .din({x_s.tlast, x_s.tdata}),
    .pop(w_pop), .dout(w_x_dout), .full(w_x_full), .empty(w_x_empty)
  );

  sync_fifo #(.WIDTH(BIN_W+1), .DEPTH(FIFO_DEPTH)) u_y_fifo (
    .clk(clk), .rst(rst), .push(w_y_push), .din({y_s.tlast, y_s.tdata}),
    .pop(w_pop), .dout(w_y_dout), .full(w_y_full), .empty(w_y_empty)
  );

  // p0: pop decision and tlast consistency on the FIFO heads
  assign w_pop      = !w_x_empty && !w_y_empty && (r_state != GAP);
  assign w_last_bin = (r_cnt == IDX_W'(NFFT-1));
  assign w_any_last = w_x_dout[BIN_W] || w_y_dout[BIN_W];
  assign w_err      = w_last_bin ? !(w_x_dout[BIN_W] && w_y_dout[BIN_W]) : w_any_last;

  // p1: registered pair, index and frame envelope
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_bin_idx_p1 <= '0;
      r_vld_p1     <= 1'b0;
      r_fov_p1     <= 1'b0;
      r_err_p1     <= 1'b0;
      r_x_re_p1    <= '0;
      r_x_im_p1    <= '0;
      r_y_re_p1    <= '0;
      r_y_im_p1    <= '0;
    end else begin
      r_vld_p1 <= w_pop;
      r_err_p1 <= w_pop && w_err;
      case (r_state)
        GAP: begin
          r_state      <= IDLE;
          r_fov_p1     <= 1'b0;
          r_bin_idx_p1 <= '0;
        end
        default: begin
          if (w_pop) begin
            r_bin_idx_p1 <= r_cnt;
            r_fov_p1     <= 1'b1;
            r_x_re_p1    <= bin_re(w_x_dout[BIN_W-1:0]);
            r_x_im_p1    <= bin_im(w_x_dout[BIN_W-1:0]);
            r_y_re_p1    <= bin_re(w_y_dout[BIN_W-1:0]);
            r_y_im_p1    <= bin_im(w_y_dout[BIN_W-1:0]);
            // Any tlast resyncs the frame; otherwise the frame closes at NFFT-1.
            if (w_last_bin || w_any_last) begin
              r_state <= GAP;
              r_cnt   <= '0;
            end else begin
              r_state <= FRAME;
              r_cnt   <= r_cnt + IDX_W'(1);
            end
          end
        end
      endcase
    end
  end

`ifdef FFT_ALIGN_ERR_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                err_cnt <= '0;
    else if (w_pop && w_err) err_cnt <= sat_inc(err_cnt);
  end
`endif

  assign x_re          = r_x_re_p1;
  assign x_im          = r_x_im_p1;
  assign y_re          = r_y_re_p1;
  assign y_im          = r_y_im_p1;
  assign pair_valid    = r_vld_p1;
  assign bin_idx       = r_bin_idx_p1;
  assign fft_out_valid = r_fov_p1;
  assign align_err     = r_err_p1;
endmodule

// File: tb/tb_fft_pair_align.sv
// Directed bench for fft_pair_align: streaming, skew, gaps, tlast resync, backpressure, reset.
module tb_fft_pair_align;
  localparam int NFFT  = 2048;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_pair_align_if x_if();
  fft_pair_align_if y_if();

  logic signed [23:0] x_re, x_im, y_re, y_im;
  logic               pair_valid, fov, align_err;
  logic [10:0]        bin_idx;
`ifdef FFT_ALIGN_ERR_CNT_EN
  logic [15:0]        err_cnt;
`endif

  fft_pair_align #(.NFFT(NFFT), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .x_s(x_if), .y_s(y_if),
    .x_re(x_re), .x_im(x_im), .y_re(y_re), .y_im(y_im),
    .pair_valid(pair_valid), .bin_idx(bin_idx), .fft_out_valid(fov),
`ifdef FFT_ALIGN_ERR_CNT_EN
    .err_cnt(err_cnt),
`endif
    .align_err(align_err)
  );

  int tests = 0;
  int fails = 0;

  bit stat_clr = 1'b0;
  bit chk_en   = 1'b1;
  int n_pv = 0, n_err = 0, bad = 0, n_fov = 0, low_run = 0, last_low_run = -1;
  int fov_drop = 0, n_xacc = 0, n_xnr = 0, err_bin = -1, post_bin = -1, exp_k = 0;
  bit seen_hi = 1'b0, got_err = 1'b0, in_frame = 1'b0;

  always @(negedge clk) begin
    if (stat_clr) begin
      n_pv <= 0; n_err <= 0; bad <= 0; n_fov <= 0; low_run <= 0; last_low_run <= -1;
      fov_drop <= 0; n_xacc <= 0; n_xnr <= 0; err_bin <= -1; post_bin <= -1; exp_k <= 0;
      seen_hi <= 1'b0; got_err <= 1'b0; in_frame <= 1'b0;
    end else begin
      if (x_if.tvalid && x_if.tready) n_xacc <= n_xacc + 1;
      if (!x_if.tready) n_xnr <= n_xnr + 1;
      if (fov) begin
        n_fov   <= n_fov + 1;
        seen_hi <= 1'b1;
        low_run <= 0;
        if (seen_hi && low_run > 0) last_low_run <= low_run;
      end else if (seen_hi) begin
        low_run <= low_run + 1;
      end
      if (align_err) begin
        n_err <= n_err + 1;
        if (!got_err) begin
          got_err <= 1'b1;
          err_bin <= int'(bin_idx);
        end
      end
      if (pair_valid) begin
        n_pv <= n_pv + 1;
        if (!fov) fov_drop <= fov_drop + 1;
        if (got_err && post_bin < 0) post_bin <= int'(bin_idx);
        if (chk_en) begin
          if (int'(x_re) != exp_k || int'(y_re) != exp_k + 4096 || int'(x_im) != -exp_k ||
              int'(y_im) != exp_k || int'(bin_idx) != exp_k)
            bad <= bad + 1;
          exp_k <= (exp_k + 1) % NFFT;
        end
        in_frame <= !(int'(bin_idx) == NFFT-1 || align_err);
      end else if (in_frame && !fov) begin
        fov_drop <= fov_drop + 1;
      end
    end
  end

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    cyc(1);
    stat_clr = 1'b1;
    cyc(1);
    stat_clr = 1'b0;
  endtask

  task automatic send_x(input int n, input int maxgap, input int dly);
    cyc(dly);
    for (int i = 0; i < n; i++) begin
      int k;
      int g;
      int t;
      bit hs;
      k = i % NFFT;
      g = (maxgap > 0) ? int'($urandom_range(maxgap)) : 0;
      x_if.tvalid = 1'b0;
      cyc(g);
      x_if.tvalid = 1'b1;
      x_if.tdata  = {24'(-k), 24'(k)};
      x_if.tlast  = (k == NFFT-1);
      t  = 0;
      hs = 1'b0;
      do begin
        @(negedge clk);
        hs = x_if.tready;
        cyc(1);
        t++;
      end while (!hs && t < 2000);
      if (!hs) chk("x_handshake_timeout", 0, 1);
    end
    x_if.tvalid = 1'b0;
    x_if.tlast  = 1'b0;
  endtask

  task automatic send_y(input int n, input int maxgap, input int dly, input int yl);
    cyc(dly);
    for (int i = 0; i < n; i++) begin
      int k;
      int g;
      int t;
      bit hs;
      k = i % NFFT;
      g = (maxgap > 0) ? int'($urandom_range(maxgap)) : 0;
      y_if.tvalid = 1'b0;
      cyc(g);
      y_if.tvalid = 1'b1;
      y_if.tdata  = {24'(k), 24'(k + 4096)};
      y_if.tlast  = (k == NFFT-1) || (i == yl);
      t  = 0;
      hs = 1'b0;
      do begin
        @(negedge clk);
        hs = y_if.tready;
        cyc(1);
        t++;
      end while (!hs && t < 2000);
      if (!hs) chk("y_handshake_timeout", 0, 1);
    end
    y_if.tvalid = 1'b0;
    y_if.tlast  = 1'b0;
  endtask

  initial begin
    x_if.tvalid = 1'b0; x_if.tlast = 1'b0; x_if.tdata = '0;
    y_if.tvalid = 1'b0; y_if.tlast = 1'b0; y_if.tdata = '0;

    // Reset state
    cyc(3);
    chk("rst_pair_valid", int'(pair_valid), 0);
    chk("rst_fov", int'(fov), 0);
    chk("rst_bin_idx", int'(bin_idx), 0);
    chk("rst_x_re", int'(x_re), 0);
    rst = 1'b0;
    cyc(1);
    chk("rst_x_tready", int'(x_if.tready), 1);
    chk("rst_y_tready", int'(y_if.tready), 1);

    // Two back-to-back frames, no stalls
    clr();
    fork
      send_x(2 * NFFT, 0, 0);
      send_y(2 * NFFT, 0, 0, -1);
    join
    cyc(8);
    chk("p1_pairs", n_pv, 2 * NFFT);
    chk("p1_bad", bad, 0);
    chk("p1_err", n_err, 0);
    chk("p1_fov_cycles", n_fov, 2 * NFFT);
    chk("p1_fov_low_between", last_low_run, 1);
    chk("p1_fov_drop", fov_drop, 0);
    chk("p1_fov_idle", int'(fov), 0);
    chk("p1_idx_idle", int'(bin_idx), 0);
    chk("p1_hold_x_re", int'(x_re), NFFT - 1);

    // y skewed 10 cycles behind x
    clr();
    fork
      send_x(NFFT, 0, 0);
      send_y(NFFT, 0, 10, -1);
    join
    cyc(8);
    chk("p2_x_tready_low", n_xnr, 0);
    chk("p2_pairs", n_pv, NFFT);
    chk("p2_bad", bad, 0);
    chk("p2_err", n_err, 0);

    // Random 0-5 cycle gaps on both channels
    clr();
    fork
      send_x(NFFT, 5, 0);
      send_y(NFFT, 5, 0, -1);
    join
    cyc(8);
    chk("p3_pairs", n_pv, NFFT);
    chk("p3_bad", bad, 0);
    chk("p3_fov_drop", fov_drop, 0);
    chk("p3_err", n_err, 0);

    // Early y tlast at bin 2000 forces a resync
    chk_en = 1'b0;
    clr();
    fork
      send_x(2002, 0, 0);
      send_y(2002, 0, 0, 2000);
    join
    cyc(8);
    chk("p4_err_count", n_err, 1);
    chk("p4_err_bin", err_bin, 2000);
    chk("p4_next_bin", post_bin, 0);
    chk("p4_fov_low", last_low_run, 1);
`ifdef FFT_ALIGN_ERR_CNT_EN
    chk("p4_err_cnt", int'(err_cnt), 1);
`endif

    // Reset in the middle of a frame
    clr();
    fork
      send_x(700, 0, 0);
      send_y(700, 0, 0, -1);
    join
    cyc(3);
    chk("p5_hold_pv", int'(pair_valid), 0);
    chk("p5_hold_x_re", int'(x_re), 699);
    chk("p5_hold_y_re", int'(y_re), 699 + 4096);
    #3 rst = 1'b1;
    #1;
    chk("p5_rst_x_re", int'(x_re), 0);
    chk("p5_rst_y_im", int'(y_im), 0);
    chk("p5_rst_fov", int'(fov), 0);
    chk("p5_rst_bin_idx", int'(bin_idx), 0);
    chk("p5_rst_align_err", int'(align_err), 0);
`ifdef FFT_ALIGN_ERR_CNT_EN
    chk("p5_rst_err_cnt", int'(err_cnt), 0);
`endif
    @(posedge clk);
    #1 rst = 1'b0;
    chk_en = 1'b1;
    clr();
    fork
      send_x(NFFT, 0, 0);
      send_y(NFFT, 0, 0, -1);
    join
    cyc(8);
    chk("p5_pairs", n_pv, NFFT);
    chk("p5_bad", bad, 0);
    chk("p5_err", n_err, 0);

    // y silent while x sends 20 bins
    clr();
    fork
      send_x(20, 0, 0);
      begin
        cyc(30);
        chk("p6_x_accepted", n_xacc, DEPTH);
        chk("p6_x_tready", int'(x_if.tready), 0);
        chk("p6_no_pairs", n_pv, 0);
        send_y(20, 0, 0, -1);
      end
    join
    cyc(8);
    chk("p6_pairs", n_pv, 20);
    chk("p6_bad", bad, 0);
    chk("p6_x_tready_after", int'(x_if.tready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fft_pair_align.md
FFT_PAIR_ALIGN -- requirements
Module: fft_pair_align

Interface
REQ-001 The block SHALL have parameter NFFT, default 2048, meaning bins per FFT frame (power of two).
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 16, meaning entries per channel FIFO (power of two, at least 4).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, the reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port x_tdata, input, 48, reference-channel FFT bin: [47:24] imaginary, [23:0] real, both signed.
REQ-006 The block SHALL have ports x_tvalid (input, 1), x_tlast (input, 1) and x_tready (output, 1), the AXI-stream handshake for the x channel.
REQ-007 The block SHALL have ports y_tdata (input, 48), y_tvalid (input, 1), y_tlast (input, 1) and y_tready (output, 1), the same for the measured channel.
REQ-008 The block SHALL have outputs x_re, x_im, y_re and y_im, each 24-bit signed, carrying the aligned bin pair.
REQ-009 The block SHALL have output pair_valid, 1, a one-cycle strobe per aligned pair.
REQ-010 The block SHALL have output bin_idx, width log2(NFFT), the index of the current pair within its frame.
REQ-011 The block SHALL have output fft_out_valid, 1, the frame envelope.
REQ-012 The block SHALL have output align_err, 1, a one-cycle pulse on a tlast mismatch.

Function
REQ-013 Each channel SHALL push into its own FIFO on tvalid&&tready; tready SHALL equal !full.
REQ-014 Each FIFO entry SHALL store {tlast, tdata}, 49 bits.
REQ-015 A pair SHALL be popped only when both FIFOs are non-empty, at most one pair per cycle.
REQ-016 Outputs x_*/y_* and pair_valid SHALL be registered: one cycle after the pop, with latency 2 cycles from a push into an empty FIFO.
REQ-017 Data outputs SHALL hold their last value while pair_valid is low.
REQ-018 The FSM SHALL have states IDLE, FRAME and GAP.
REQ-019 IDLE -> FRAME SHALL occur on the first pop.
REQ-020 In FRAME, bin_idx SHALL increment per pop.
REQ-021 FRAME -> GAP SHALL occur on the pop where bin_idx==NFFT-1.
REQ-022 GAP SHALL last exactly 1 cycle, during which pops are stalled, then return to IDLE.
REQ-023 fft_out_valid SHALL be 1 from the cycle the first pair_valid of a frame is asserted through the cycle the last pair_valid is asserted, and 0 during GAP and IDLE, so the downstream stage always sees a falling edge between frames.
REQ-024 fft_out_valid SHALL stay 1 across FIFO-empty gaps inside a frame.
REQ-025 If either popped tlast is set when bin_idx!=NFFT-1, or bin_idx==NFFT-1 and either tlast is clear, align_err SHALL pulse with that pair's pair_valid.
REQ-026 After such a mismatch, if any tlast was set, the FSM SHALL go to GAP and bin_idx SHALL restart at 0 (resync on tlast); otherwise the frame SHALL end normally at NFFT-1.
REQ-027 bin_idx SHALL wrap from NFFT-1 to 0 and SHALL be 0 in IDLE.
REQ-028 A simultaneous push and pop on the same FIFO SHALL be legal when full or empty: push is accepted when full only if a pop occurs in the same cycle; pop on empty with push is not a bypass.

Reset
REQ-029 On rst, both FIFOs SHALL empty, the FSM SHALL go to IDLE, and bin_idx, pair_valid, fft_out_valid, align_err and x_*/y_* SHALL be 0.
REQ-030 On rst, tready SHALL be 1 from the first clock after deassertion.
REQ-031 Reset mid-frame SHALL discard the partial frame without asserting align_err.

Configuration
REQ-032 With FFT_ALIGN_ERR_CNT_EN defined, the block SHALL add output err_cnt, 16 bits, incremented on each align_err pulse, saturating at 0xFFFF, cleared only by rst.
REQ-033 Without FFT_ALIGN_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent.

Structure
REQ-034 Package fft_cal_pkg SHALL hold NFFT_DEFAULT=2048, SAMPLE_W=24, BIN_W=48 and the FSM state enum.
REQ-035 The design SHALL contain one sub-module, sync_fifo (parameterised width/depth, registered full/empty), instantiated twice.

Verification
REQ-036 Both channels streaming 2048 bins with tlast at 2047 and no stalls -> 2048 pair_valid; bin_idx 0..2047; fft_out_valid high for 2048 cycles then low for 1; align_err never set.
REQ-037 y delayed 10 cycles relative to x, with x FIFO depth 16 -> x_tready stays high; pairs match bin-for-bin (x_re==bin, y_re==bin+0x1000).
REQ-038 Random tvalid gaps of 0-5 cycles on each channel -> pairs correct in order; fft_out_valid never drops mid-frame.
REQ-039 y_tlast at bin 2000 -> align_err pulses at bin_idx 2000; the next pair has bin_idx 0 after a one-cycle fft_out_valid low; with the macro defined, err_cnt==1.
REQ-040 y_tvalid held low while x sends 20 bins -> x_tready falls after 16 accepted; no pair_valid until y resumes.
REQ-041 rst asserted at bin 700 -> all outputs 0 immediately; the next frame starts at bin_idx 0 with no align_err.
